// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_loader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wr;
    logic              mem_rd;

    // Loader side: consumes the byte stream, drives the memory port
    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_addr, mem_din, mem_wr, mem_rd
    );

    // Source/memory side
    modport master (
        output in_data, in_valid,
        input  in_ready, mem_addr, mem_din, mem_wr, mem_rd
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles a byte-serial image into words and writes instruction memory
module imem_loader #(
    parameter int ADDR_W    = 5,
    parameter int BASE_ADDR = 4,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_loader_if.slave      bus,
    input  logic              reload,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] words_loaded
);
    // Largest image that fits between the reset PC and the top of memory
    localparam int MAX_WORDS = (1 << ADDR_W) - BASE_ADDR;

    typedef enum logic [2:0] {IDLE, BYTES, WRITE, DONE, ERR} state_t;

    state_t            state, state_d;
    logic [1:0]        byte_cnt, byte_cnt_d;
    logic [DATA_W-1:0] word, word_d;
    logic [7:0]        n_words, n_words_d;
    logic              in_ready_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_din_d;
    logic              mem_wr_d;
    logic              load_done_d;
    logic              load_err_d;
    logic [ADDR_W-1:0] words_loaded_d;
    logic              xfer;
    logic [DATA_W-1:0] shifted;

    assign xfer    = bus.in_valid && bus.in_ready;
    // Big-endian: the first byte ends up in the top lane after four shifts
    assign shifted = {word[DATA_W-9:0], bus.in_data};

    // Next state and next value of every registered output
    always_comb begin
        state_d        = state;
        byte_cnt_d     = byte_cnt;
        word_d         = word;
        n_words_d      = n_words;
        in_ready_d     = bus.in_ready;
        mem_addr_d     = bus.mem_addr;
        mem_din_d      = bus.mem_din;
        mem_wr_d       = 1'b0;
        load_done_d    = load_done;
        load_err_d     = load_err;
        words_loaded_d = words_loaded;
        case (state)
            IDLE: begin
                in_ready_d = 1'b1;
                if (xfer) begin
                    if (bus.in_data == 8'd0 || int'(bus.in_data) > MAX_WORDS) begin
                        state_d    = ERR;
                        in_ready_d = 1'b0;
                        load_err_d = 1'b1;
                    end else begin
                        state_d    = BYTES;
                        n_words_d  = bus.in_data;
                        mem_addr_d = ADDR_W'(BASE_ADDR);
                        byte_cnt_d = 2'd0;
                    end
                end
            end
            BYTES: begin
                in_ready_d = 1'b1;
                if (xfer) begin
                    word_d     = shifted;
                    byte_cnt_d = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        state_d    = WRITE;
                        mem_din_d  = shifted;
                        mem_wr_d   = 1'b1;
                        in_ready_d = 1'b0;
                    end
                end
            end
            WRITE: begin
                words_loaded_d = words_loaded + ADDR_W'(1);
                if (int'(words_loaded) + 1 == int'(n_words)) begin
                    // Pointer stays on the last written address
                    state_d     = DONE;
                    in_ready_d  = 1'b0;
                    load_done_d = 1'b1;
                end else begin
                    state_d    = BYTES;
                    in_ready_d = 1'b1;
                    mem_addr_d = bus.mem_addr + ADDR_W'(1);
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (reload) begin
                    state_d        = IDLE;
                    in_ready_d     = 1'b1;
                    load_done_d    = 1'b0;
                    words_loaded_d = '0;
                    mem_addr_d     = ADDR_W'(BASE_ADDR);
                end
            end
            ERR: begin
                in_ready_d = 1'b0;
                if (reload) begin
                    state_d    = IDLE;
                    in_ready_d = 1'b1;
                    load_err_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any load in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            byte_cnt     <= 2'd0;
            word         <= '0;
            n_words      <= 8'd0;
            bus.in_ready <= 1'b0;
            bus.mem_addr <= ADDR_W'(BASE_ADDR);
            bus.mem_din  <= '0;
            bus.mem_wr   <= 1'b0;
            bus.mem_rd   <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_d;
            byte_cnt     <= byte_cnt_d;
            word         <= word_d;
            n_words      <= n_words_d;
            bus.in_ready <= in_ready_d;
            bus.mem_addr <= mem_addr_d;
            bus.mem_din  <= mem_din_d;
            bus.mem_wr   <= mem_wr_d;
            bus.mem_rd   <= 1'b0;
            load_done    <= load_done_d;
            load_err     <= load_err_d;
            words_loaded <= words_loaded_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       reload = 1'b0;
    logic       load_done;
    logic       load_err;
    logic [4:0] words_loaded;

    int tests = 0;
    int fails = 0;

    imem_loader_if #(.ADDR_W(5), .DATA_W(32)) bus();

    imem_loader #(.ADDR_W(5), .BASE_ADDR(4), .DATA_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .reload       (reload),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    logic [31:0] mem [0:31];
    int          wr_cnt = 0;
    int          last_wr_edge = 0;
    int          prev_wr_edge = 0;
    logic [4:0]  last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic        last_wr = 1'b0;
    logic        consec_wr = 1'b0;
    logic        rd_seen = 1'b0;
    logic        audit_en = 1'b0;
    int          bad_ready = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model and port observers; mem_wr seen here lands on the next edge
    always @(negedge clk) begin
        if (bus.mem_wr === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_din;
            wr_cnt            <= wr_cnt + 1;
            prev_wr_edge      <= last_wr_edge;
            last_wr_edge      <= cyc + 1;
            last_wr_addr      <= bus.mem_addr;
            last_wr_data      <= bus.mem_din;
            if (last_wr) consec_wr <= 1'b1;
        end
        last_wr <= (bus.mem_wr === 1'b1);
        if (bus.mem_rd !== 1'b0) rd_seen <= 1'b1;
        if (audit_en && rst_n &&
            bus.in_ready !== (!bus.mem_wr && !load_done && !load_err))
            bad_ready <= bad_ready + 1;
    end

    // Offer a byte from a negedge; returns on the negedge after it is taken
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, bus.in_ready);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({bus.in_ready, bus.mem_wr, bus.mem_rd, load_done, load_err} !== 5'b0 ||
            bus.mem_addr !== 5'd4 || bus.mem_din !== 32'h0 || words_loaded !== 5'd0) begin
            fails++;
            $display("FAIL reset_values rdy=%b wr=%b rd=%b addr=%0d din=%h done=%b err=%b wl=%0d required 0,0,0,4,0,0,0,0",
                     bus.in_ready, bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_din, load_done, load_err, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL ready_after_release got=%b required 0", bus.in_ready);
        end
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL ready_first_clock got=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_two_word();
        int h;
        int w0;
        w0 = wr_cnt;
        send_byte(8'h02);
        h = cyc;
        send_word(32'h08800041);
        send_word(32'h10C00082);
        tests++;
        if (load_done !== 1'b0) begin
            fails++; $display("FAIL done_early got=%b required 0", load_done);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        tests++;
        if (load_done !== 1'b1 || cyc != h + 10) begin
            fails++; $display("FAIL done_latency done=%b edge=%0d required 1 at %0d", load_done, cyc - h, 10);
        end
        @(negedge clk);
        tests++;
        if (mem[4] !== 32'h08800041 || mem[5] !== 32'h10C00082) begin
            fails++; $display("FAIL two_word_mem m4=%h m5=%h required 08800041 10C00082", mem[4], mem[5]);
        end
        tests++;
        if (wr_cnt - w0 != 2 || prev_wr_edge != h + 5 || last_wr_edge != h + 10) begin
            fails++; $display("FAIL two_word_writes n=%0d e0=%0d e1=%0d required 2 5 10",
                              wr_cnt - w0, prev_wr_edge - h, last_wr_edge - h);
        end
        tests++;
        if (words_loaded !== 5'd2 || bus.mem_addr !== 5'd5) begin
            fails++; $display("FAIL two_word_count wl=%0d addr=%0d required 2 5", words_loaded, bus.mem_addr);
        end
        tests++;
        if (rd_seen !== 1'b0 || consec_wr !== 1'b0) begin
            fails++; $display("FAIL port_rules rd_seen=%b consec_wr=%b required 0 0", rd_seen, consec_wr);
        end
    endtask

    task automatic test_reload_done();
        pulse_reload();
        tests++;
        if (load_done !== 1'b0 || words_loaded !== 5'd0 || bus.mem_addr !== 5'd4 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reload_done done=%b wl=%0d addr=%0d rdy=%b required 0 0 4 1",
                              load_done, words_loaded, bus.mem_addr, bus.in_ready);
        end
        send_byte(8'h01);
        send_word(32'hDEADBEEF);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (mem[4] !== 32'hDEADBEEF || last_wr_addr !== 5'd4 || load_done !== 1'b1 || words_loaded !== 5'd1) begin
            fails++; $display("FAIL reload_next_image m4=%h addr=%0d done=%b wl=%0d required DEADBEEF 4 1 1",
                              mem[4], last_wr_addr, load_done, words_loaded);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] img [9] = '{8'h02, 8'h08, 8'h80, 8'h00, 8'h41, 8'h10, 8'hC0, 8'h00, 8'h82};
        int w0;
        pulse_reload();
        w0 = wr_cnt;
        audit_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_byte(img[i]);
            if (i % 2 == 1) begin
                bus.in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        audit_en = 1'b0;
        @(negedge clk);
        tests++;
        if (mem[4] !== 32'h08800041 || mem[5] !== 32'h10C00082 || last_wr_data !== 32'h10C00082) begin
            fails++; $display("FAIL backpressure_mem m4=%h m5=%h last=%h required 08800041 10C00082",
                              mem[4], mem[5], last_wr_data);
        end
        tests++;
        if (wr_cnt - w0 != 2 || load_done !== 1'b1 || words_loaded !== 5'd2) begin
            fails++; $display("FAIL backpressure_count n=%0d done=%b wl=%0d required 2 1 2",
                              wr_cnt - w0, load_done, words_loaded);
        end
        tests++;
        if (bad_ready != 0) begin
            fails++; $display("FAIL ready_profile bad_cycles=%0d required 0", bad_ready);
        end
    endtask

    task automatic test_bad_header(input logic [7:0] hdr);
        int w0;
        w0 = wr_cnt;
        send_byte(hdr);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (load_err !== 1'b1 || bus.in_ready !== 1'b0 || wr_cnt != w0 || load_done !== 1'b0) begin
            fails++; $display("FAIL header_%h err=%b rdy=%b writes=%0d done=%b required 1 0 0 0",
                              hdr, load_err, bus.in_ready, wr_cnt - w0, load_done);
        end
        pulse_reload();
        tests++;
        if (load_err !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL reload_err_%h err=%b rdy=%b required 0 1", hdr, load_err, bus.in_ready);
        end
    endtask

    task automatic test_max_image();
        logic [31:0] exp;
        int w0;
        w0 = wr_cnt;
        send_byte(8'h1C);
        for (int i = 0; i < 112; i++) send_byte(8'(i));
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 28; k++) begin
            exp = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            tests++;
            if (mem[k+4] !== exp) begin
                fails++; $display("FAIL max_mem[%0d] got=%h required %h", k + 4, mem[k+4], exp);
            end
        end
        tests++;
        if (wr_cnt - w0 != 28 || bus.mem_addr !== 5'd31 || load_done !== 1'b1 || words_loaded !== 5'd28) begin
            fails++; $display("FAIL max_image n=%0d addr=%0d done=%b wl=%0d required 28 31 1 28",
                              wr_cnt - w0, bus.mem_addr, load_done, words_loaded);
        end
    endtask

    task automatic test_reload_in_bytes();
        pulse_reload();
        send_byte(8'h02);
        send_byte(8'hCA);
        send_byte(8'hFE);
        bus.in_valid = 1'b0;
        pulse_reload();
        tests++;
        if (bus.in_ready !== 1'b1 || words_loaded !== 5'd0) begin
            fails++; $display("FAIL reload_ignored rdy=%b wl=%0d required 1 0", bus.in_ready, words_loaded);
        end
        send_byte(8'hF0);
        send_byte(8'h0D);
        send_word(32'h12345678);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (mem[4] !== 32'hCAFEF00D || mem[5] !== 32'h12345678 || load_done !== 1'b1 || words_loaded !== 5'd2) begin
            fails++; $display("FAIL reload_in_bytes m4=%h m5=%h done=%b wl=%0d required CAFEF00D 12345678 1 2",
                              mem[4], mem[5], load_done, words_loaded);
        end
    endtask

    task automatic test_reset_midload();
        pulse_reload();
        send_byte(8'h03);
        send_word(32'h11223344);
        send_byte(8'h55);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.in_ready, bus.mem_wr, bus.mem_rd, load_done, load_err} !== 5'b0 ||
            bus.mem_addr !== 5'd4 || bus.mem_din !== 32'h0 || words_loaded !== 5'd0) begin
            fails++; $display("FAIL async_reset rdy=%b wr=%b addr=%0d din=%h done=%b wl=%0d required 0 0 4 0 0 0",
                              bus.in_ready, bus.mem_wr, bus.mem_addr, bus.mem_din, load_done, words_loaded);
        end
        tests++;
        if (mem[4] !== 32'h11223344) begin
            fails++; $display("FAIL kept_word got=%h required 11223344", mem[4]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h01);
        send_word(32'hA5B6C7D8);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (mem[4] !== 32'hA5B6C7D8 || load_done !== 1'b1 || words_loaded !== 5'd1) begin
            fails++; $display("FAIL after_reset m4=%h done=%b wl=%0d required A5B6C7D8 1 1",
                              mem[4], load_done, words_loaded);
        end
    endtask

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_two_word();
        test_reload_done();
        test_backpressure();
        pulse_reload();
        test_bad_header(8'h00);
        test_bad_header(8'h1D);
        test_max_image();
        test_reload_in_bytes();
        test_reset_midload();
        tests++;
        if (consec_wr !== 1'b0 || rd_seen !== 1'b0) begin
            fails++; $display("FAIL final_port_rules consec_wr=%b rd_seen=%b required 0 0", consec_wr, rd_seen);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t required finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
